instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Program-counter and fetch stage directly upstream of instruction_memory. Drives its byte address and consumes its 32-bit data_out.
- Captures instruction plus PC into a valid/ready IF/ID output register for decode.
- Handles sequential advance, branch/jump redirect, halt, and a loader-busy interlock. Supports one instruction per cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_DEPTH, 2048, instruction memory size in bytes (power of two)
- XLEN, 32, PC/instruction width

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- imem_addr  out  XLEN  byte address to instruction memory; combinational copy of pc
- imem_data  in  XLEN  instruction memory data_out; updated by memory at negedge
- imem_busy  in  1  loader writing instruction memory this cycle; fetch must not capture
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  XLEN  redirect target
- halt_req  in  1  stop fetching (ecall/ebreak/debug)
- id_ready  in  1  decode accepts id_* this cycle
- id_valid  out  1  id_* holds a valid instruction
- id_instr  out  XLEN  fetched instruction
- id_pc  out  XLEN  address of id_instr
- id_pc_plus4  out  XLEN  id_pc+4 (for JAL/JALR link)
- fetch_halted  out  1  FSM in HALT
- fetch_fault  out  1  fetch address fault (only meaningful with FETCH_FAULT_EN)

Behaviour:
- Reset values (while rst=1 at posedge):
  - pc=RESET_PC, state=BOOT, id_valid=0
  - id_instr=32'h0000_0013 (NOP), id_pc=0, id_pc_plus4=0
  - fetch_halted=0, fetch_fault=0
  - Reset mid-operation discards everything, including a pending redirect.
- Memory timing:
  - pc changes at posedge N, memory reads mem[pc] at the following negedge, and imem_data is sampled at posedge N+1.
  - Latency is one cycle from pc update to capture; throughput is 1 instruction/cycle.
- load = !id_valid || id_ready; cap = (state==RUN) && load && !imem_busy.
- FSM states: BOOT, RUN, HALT.
  - BOOT:
    - No capture, pc held.
    - -> RUN at posedge where imem_busy==0. That cycle's memory read is discarded.
    - redirect_valid in BOOT loads pc and stays in BOOT.
  - RUN, priority redirect > halt > cap:
    - redirect_valid: pc<=redirect_pc, id_valid<=0 (flush, even if id_ready=0), no capture. The redirected instruction appears one cycle later.
    - halt_req: -> HALT, pc held, no capture. A held id_valid drains normally (cleared on id_ready).
    - cap: id_instr<=imem_data, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
    - !cap and id_ready && id_valid: id_valid<=0.
    - Otherwise: everything holds. While imem_busy=1 in RUN, pc holds and output drains.
  - HALT:
    - fetch_halted=1.
    - Only redirect_valid exits: pc<=redirect_pc, -> RUN, fetch_halted<=0.
    - halt_req ignored while in HALT.
- Arithmetic: pc+4 modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- Simultaneous events:
  - redirect_valid and halt_req in the same cycle: redirect wins, halt dropped.
  - id_ready with redirect: output flushed; the accepted instruction was already consumed by decode that cycle.

Optional Feature:
- Macro FETCH_FAULT_EN.
- Defined:
  - imem_addr=pc unmodified.
  - If state==RUN and (pc[1:0]!=0 or pc>IMEM_DEPTH-4): no capture, fetch_fault<=1, -> HALT.
  - fetch_fault clears on redirect exit from HALT or on reset.
- Not defined:
  - fetch_fault tied 0.
  - imem_addr = {pc[XLEN-1:2],2'b00} masked to IMEM_DEPTH-1 (wraps inside memory).
  - redirect_pc[1:0] forced to 00 when loaded.

Decomposition:
- Package fetch_pkg:
  - state enum {BOOT,RUN,HALT}
  - NOP_INSTR=32'h0000_0013
  - default RESET_PC and IMEM_DEPTH
  - constant PC_STEP=4
- Sub-module fetch_out_reg: the valid/ready IF/ID holding register with flush input (id_instr, id_pc, id_pc_plus4, id_valid). FSM and pc logic remain in instruction_fetch.

Test Plan:
- Reset, imem_busy=0, id_ready=1, mem[0..12]=13,93,33,B3 words:
  - BOOT 1 cycle, then id_pc=0,4,8,C on consecutive cycles with matching id_instr.
  - imem_addr=0,4,8,C,10.
- Backpressure: id_ready=0 for 3 cycles while id_pc=4 valid:
  - id_instr/id_pc held, pc stays 8.
  - Resumes with id_pc=8 the cycle after id_ready=1; no skip, no duplicate.
- Redirect at pc=8, target 0x40, id_ready=0:
  - Next cycle id_valid=0, imem_addr=0x40.
  - Following cycle id_pc=0x40.
- halt_req at pc=0x10:
  - fetch_halted=1, imem_addr stays 0x10, no new id_valid.
  - Redirect 0x20 resumes with id_pc=0x20.
- imem_busy=1 for 4 cycles after reset, then 0:
  - No id_valid during busy.
  - First id_pc=RESET_PC two cycles after busy falls.
  - Busy pulse in RUN freezes pc.
- With FETCH_FAULT_EN: redirect to 0x802 and separately to 0x800 (IMEM_DEPTH=2048):
  - fetch_fault=1, HALT, id_valid stays 0.
  - Without the macro: 0x802 fetches word 0x000 and fetch_fault stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e      : fetch FSM states (BOOT, RUN, HALT)
//   NOP_INSTR          : canonical RV32 NOP (addi x0,x0,0) shown in an empty IF/ID
//   DEFAULT_RESET_PC   : default PC loaded on reset
//   DEFAULT_IMEM_DEPTH : default instruction memory size in bytes
//   PC_STEP            : sequential PC increment in bytes
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_IMEM_DEPTH = 2048;
  localparam int          PC_STEP            = 4;

endpackage

// File: rtl/fetch_out_reg.sv
// -----------------------------------------------------------------------------
// fetch_out_reg
// Valid/ready IF/ID holding register. Captures a fetched instruction with its
// PC and PC+4, holds it while decode stalls, and drops it on a flush.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : discard the held instruction (redirect)
//   cap             : load cap_* into the register (wins over drain)
//   cap_instr/pc/pc_plus4 : data to capture
//   id_ready        : decode consumes the held instruction this cycle
//   id_valid, id_instr, id_pc, id_pc_plus4 : registered outputs to decode
// -----------------------------------------------------------------------------
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            cap,
  input  logic [XLEN-1:0] cap_instr,
  input  logic [XLEN-1:0] cap_pc,
  input  logic [XLEN-1:0] cap_pc_plus4,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  logic            valid_d, valid_q;
  logic [XLEN-1:0] instr_d, instr_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;

  // Flush beats capture; a held entry that decode accepts without a
  // replacement simply goes invalid. Data fields keep their last value.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (cap) begin
      valid_d    = 1'b1;
      instr_d    = cap_instr;
      pc_d       = cap_pc;
      pc_plus4_d = cap_pc_plus4;
    end else if (id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= XLEN'(NOP_INSTR);
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc       = pc_q;
  assign id_pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Program counter and fetch FSM feeding instruction memory and the IF/ID
// register. The memory is read on the negedge after the PC changes, so the
// word at imem_addr is ready to capture on the next posedge.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   imem_addr  (out)     : byte address to instruction memory
//   imem_data  (in)      : instruction memory read data
//   imem_busy  (in)      : loader owns the memory this cycle, do not capture
//   redirect_valid/pc    : branch/jump redirect
//   halt_req             : stop fetching
//   id_ready   (in)      : decode accepts the IF/ID entry
//   id_valid/instr/pc/pc_plus4 (out) : IF/ID entry
//   fetch_halted (out)   : FSM is in HALT
//   fetch_fault  (out)   : fetch address fault
// Build option: define FETCH_FAULT_EN to trap misaligned or out-of-range
// fetch addresses instead of aligning and wrapping them inside the memory.
// -----------------------------------------------------------------------------
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
  parameter int          XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            imem_busy,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            fetch_halted,
  output logic            fetch_fault
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] ADDR_MASK = XLEN'(IMEM_DEPTH - 1);
  localparam logic [XLEN-1:0] LAST_WORD = XLEN'(IMEM_DEPTH - PC_STEP);

  fetch_state_e    state_d, state_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_target;
  logic            load;
  logic            cap;
  logic            flush;

`ifdef FETCH_FAULT_EN
  logic            fault_d, fault_q;
  logic            pc_bad;

  assign redirect_target = redirect_pc;
  assign imem_addr       = pc_q;
  assign pc_bad          = (pc_q[1:0] != 2'b00) || (pc_q > LAST_WORD);
  assign fetch_fault     = fault_q;
`else
  // Without fault trapping, targets are word-aligned and the address wraps
  // inside the memory so every PC maps onto a real word.
  assign redirect_target = redirect_pc & WORD_MASK;
  assign imem_addr       = pc_q & WORD_MASK & ADDR_MASK;
  assign fetch_fault     = 1'b0;
`endif

  assign pc_plus4     = pc_q + XLEN'(PC_STEP);
  assign load         = !id_valid || id_ready;
  assign fetch_halted = (state_q == HALT);

  // Next-state and PC logic. In RUN the priority is redirect, then halt,
  // then (with fault trapping) a bad PC, then a normal capture. The BOOT
  // cycle's memory read is thrown away so the first capture uses a word
  // read while the loader was idle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cap     = 1'b0;
    flush   = 1'b0;
`ifdef FETCH_FAULT_EN
    fault_d = fault_q;
`endif
    case (state_q)
      BOOT: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (!imem_busy) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d  = redirect_target;
          flush = 1'b1;
        end else if (halt_req) begin
          state_d = HALT;
        end
`ifdef FETCH_FAULT_EN
        else if (pc_bad) begin
          fault_d = 1'b1;
          state_d = HALT;
        end
`endif
        else if (load && !imem_busy) begin
          cap  = 1'b1;
          pc_d = pc_plus4;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = RUN;
`ifdef FETCH_FAULT_EN
          fault_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= XLEN'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_FAULT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  fetch_out_reg #(
    .XLEN(XLEN)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .cap         (cap),
    .cap_instr   (imem_data),
    .cap_pc      (pc_q),
    .cap_pc_plus4(pc_plus4),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch: a directed vector table, a few
// hand-written corner sequences and a randomized run against a behavioural
// model. Honours FETCH_FAULT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 2048;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_halted;
  logic        fetch_fault;

  int total_cnt;
  int bad_cnt;

  logic [31:0] mem [0:DEPTH/4-1];

  // Behavioural model state: where fetch will read next and what decode sees.
  logic [31:0] m_pc;
  logic        m_started;
  logic        m_stopped;
  logic        m_fault;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_idpc4;

  typedef struct {
    logic        rst;
    logic        busy;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        ready;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(DEPTH),
    .XLEN      (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_busy     (imem_busy),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .fetch_halted  (fetch_halted),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    if (a < DEPTH) return mem[idx[8:0]];
    return 32'hDEAD_BEEF;
  endfunction

  // Instruction memory: reads at the negedge after the address changes.
  always @(negedge clk) begin
    imem_data = memWord(imem_addr);
  end

  function automatic logic [31:0] addrOf(input logic [31:0] p);
`ifdef FETCH_FAULT_EN
    return p;
`else
    return (p - (p % 4)) % DEPTH;
`endif
  endfunction

  function automatic logic [31:0] normTarget(input logic [31:0] t);
`ifdef FETCH_FAULT_EN
    return t;
`else
    return t - (t % 4);
`endif
  endfunction

  function automatic logic badPc(input logic [31:0] p);
`ifdef FETCH_FAULT_EN
    return (p % 4 != 0) || (p + 4 > DEPTH);
`else
    return (p != p) ? 1'b1 : 1'b0;
`endif
  endfunction

  task automatic modelStep(input logic r, input logic b, input logic d,
                           input logic [31:0] t, input logic h, input logic y);
    logic [31:0] tgt;
    logic        drain;
    tgt   = normTarget(t);
    drain = m_valid && y;
    if (r) begin
      m_pc = 32'h0; m_started = 0; m_stopped = 0; m_fault = 0;
      m_valid = 0; m_instr = NOP; m_idpc = 0; m_idpc4 = 0;
    end else if (!m_started) begin
      if (d) m_pc = tgt;
      else if (!b) m_started = 1;
    end else if (m_stopped) begin
      if (drain) m_valid = 0;
      if (d) begin m_pc = tgt; m_stopped = 0; m_fault = 0; end
    end else if (d) begin
      m_pc = tgt; m_valid = 0;
    end else if (h) begin
      m_stopped = 1;
      if (drain) m_valid = 0;
    end else if (badPc(m_pc)) begin
      m_fault = 1; m_stopped = 1;
      if (drain) m_valid = 0;
    end else if ((!m_valid || y) && !b) begin
      m_instr = memWord(addrOf(m_pc));
      m_idpc  = m_pc;
      m_idpc4 = m_pc + 32'd4;
      m_valid = 1;
      m_pc    = m_pc + 32'd4;
    end else if (drain) begin
      m_valid = 0;
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and sample after the edge.
  task automatic applyStimulus(input logic r, input logic b, input logic d,
                               input logic [31:0] t, input logic h, input logic y);
    rst = r; imem_busy = b; redirect_valid = d; redirect_pc = t;
    halt_req = h; id_ready = y;
    modelStep(r, b, d, t, h, y);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " id_valid"}, 32'(id_valid), 32'(m_valid));
    checkVal({tag, " imem_addr"}, imem_addr, addrOf(m_pc));
    checkVal({tag, " fetch_halted"}, 32'(fetch_halted), 32'(m_stopped));
    checkVal({tag, " fetch_fault"}, 32'(fetch_fault), 32'(m_fault));
    if (m_valid) begin
      checkVal({tag, " id_instr"}, id_instr, m_instr);
      checkVal({tag, " id_pc"}, id_pc, m_idpc);
      checkVal({tag, " id_pc_plus4"}, id_pc_plus4, m_idpc4);
    end
  endtask

  task automatic addRow(input logic r, input logic b, input logic d, input logic [31:0] t,
                        input logic h, input logic y, input logic ev, input logic [31:0] epc,
                        input logic [31:0] eaddr, input logic eh);
    vec_t v;
    v.rst = r; v.busy = b; v.redir = d; v.rpc = t; v.halt = h; v.ready = y;
    v.exp_valid = ev; v.chk_data = ev || r;
    v.exp_pc = r ? 32'h0 : epc;
    v.exp_instr = r ? NOP : memWord(epc);
    v.exp_addr = eaddr; v.exp_halted = eh;
    vecs.push_back(v);
  endtask

  task automatic checkRow(input int i);
    string tag;
    tag = $sformatf("row%0d", i);
    checkVal({tag, " id_valid"}, 32'(id_valid), 32'(vecs[i].exp_valid));
    checkVal({tag, " imem_addr"}, imem_addr, vecs[i].exp_addr);
    checkVal({tag, " fetch_halted"}, 32'(fetch_halted), 32'(vecs[i].exp_halted));
    checkVal({tag, " fetch_fault"}, 32'(fetch_fault), 32'h0);
    if (vecs[i].chk_data) begin
      checkVal({tag, " id_instr"}, id_instr, vecs[i].exp_instr);
      checkVal({tag, " id_pc"}, id_pc, vecs[i].exp_pc);
      checkVal({tag, " id_pc_plus4"}, id_pc_plus4,
               vecs[i].rst ? 32'h0 : vecs[i].exp_pc + 32'd4);
    end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst = 1; imem_busy = 0; redirect_valid = 0; redirect_pc = 0;
    halt_req = 0; id_ready = 1;
    for (int i = 0; i < DEPTH / 4; i++) mem[i] = 32'hA000_0000 | (i << 2);
    mem[0] = 32'h13; mem[1] = 32'h93; mem[2] = 32'h33; mem[3] = 32'hB3;

    // Sequential fetch after reset
    addRow(1,0,0,0,0,1, 0,0,0,0);
    addRow(0,0,0,0,0,1, 0,0,0,0);
    addRow(0,0,0,0,0,1, 1,32'h0,32'h4,0);
    addRow(0,0,0,0,0,1, 1,32'h4,32'h8,0);
    addRow(0,0,0,0,0,1, 1,32'h8,32'hC,0);
    addRow(0,0,0,0,0,1, 1,32'hC,32'h10,0);
    // Backpressure on id_pc=4
    addRow(1,0,0,0,0,1, 0,0,0,0);
    addRow(0,0,0,0,0,1, 0,0,0,0);
    addRow(0,0,0,0,0,1, 1,32'h0,32'h4,0);
    addRow(0,0,0,0,0,1, 1,32'h4,32'h8,0);
    for (int k = 0; k < 3; k++) addRow(0,0,0,0,0,0, 1,32'h4,32'h8,0);
    addRow(0,0,0,0,0,1, 1,32'h8,32'hC,0);
    // Redirect with decode stalled flushes the held entry
    addRow(0,0,1,32'h40,0,0, 0,0,32'h40,0);
    addRow(0,0,0,0,0,1, 1,32'h40,32'h44,0);
    addRow(0,0,0,0,0,1, 1,32'h44,32'h48,0);
    // Halt at 0x10, ignored repeat halt, redirect out
    addRow(0,0,1,32'h10,0,1, 0,0,32'h10,0);
    addRow(0,0,0,0,1,1, 0,0,32'h10,1);
    addRow(0,0,0,0,0,1, 0,0,32'h10,1);
    addRow(0,0,0,0,1,1, 0,0,32'h10,1);
    addRow(0,0,1,32'h20,0,1, 0,0,32'h20,0);
    addRow(0,0,0,0,0,1, 1,32'h20,32'h24,0);
    // Loader busy after reset, then a busy pulse in RUN
    addRow(1,1,0,0,0,1, 0,0,0,0);
    for (int k = 0; k < 4; k++) addRow(0,1,0,0,0,1, 0,0,0,0);
    addRow(0,0,0,0,0,1, 0,0,0,0);
    addRow(0,0,0,0,0,1, 1,32'h0,32'h4,0);
    addRow(0,1,0,0,0,1, 0,0,32'h4,0);
    addRow(0,1,0,0,0,1, 0,0,32'h4,0);
    addRow(0,0,0,0,0,1, 1,32'h4,32'h8,0);
    // Redirect and halt together: redirect wins
    addRow(0,0,1,32'h60,1,1, 0,0,32'h60,0);
    addRow(0,0,0,0,0,1, 1,32'h60,32'h64,0);
    // Redirect while in BOOT stays in BOOT
    addRow(1,0,0,0,0,1, 0,0,0,0);
    addRow(0,1,1,32'h30,0,1, 0,0,32'h30,0);
    addRow(0,0,0,0,0,1, 0,0,32'h30,0);
    addRow(0,0,0,0,0,1, 1,32'h30,32'h34,0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].busy, vecs[i].redir, vecs[i].rpc,
                    vecs[i].halt, vecs[i].ready);
      checkRow(i);
    end

    // Out-of-range / misaligned targets
    applyStimulus(1,0,0,0,0,1);
    applyStimulus(0,0,0,0,0,1);
`ifdef FETCH_FAULT_EN
    applyStimulus(0,0,1,32'h802,0,1);
    checkVal("f802 addr", imem_addr, 32'h802);
    checkVal("f802 fault pre", 32'(fetch_fault), 32'h0);
    applyStimulus(0,0,0,0,0,1);
    checkVal("f802 fault", 32'(fetch_fault), 32'h1);
    checkVal("f802 halted", 32'(fetch_halted), 32'h1);
    checkVal("f802 valid", 32'(id_valid), 32'h0);
    applyStimulus(0,0,1,32'h800,0,1);
    checkVal("f800 fault clr", 32'(fetch_fault), 32'h0);
    checkVal("f800 halted clr", 32'(fetch_halted), 32'h0);
    applyStimulus(0,0,0,0,0,1);
    checkVal("f800 fault", 32'(fetch_fault), 32'h1);
    checkVal("f800 halted", 32'(fetch_halted), 32'h1);
    checkVal("f800 valid", 32'(id_valid), 32'h0);
`else
    applyStimulus(0,0,1,32'h802,0,1);
    checkVal("w802 addr", imem_addr, 32'h0);
    applyStimulus(0,0,0,0,0,1);
    checkVal("w802 valid", 32'(id_valid), 32'h1);
    checkVal("w802 id_pc", id_pc, 32'h800);
    checkVal("w802 instr", id_instr, 32'h13);
    checkVal("w802 fault", 32'(fetch_fault), 32'h0);
    applyStimulus(0,0,1,32'hFFFF_FFFC,0,1);
    checkVal("wrap addr", imem_addr, 32'h7FC);
    applyStimulus(0,0,0,0,0,1);
    checkVal("wrap id_pc", id_pc, 32'hFFFF_FFFC);
    checkVal("wrap pc_plus4", id_pc_plus4, 32'h0);
    checkVal("wrap instr", id_instr, 32'hA000_07FC);
    checkVal("wrap addr next", imem_addr, 32'h0);
`endif

    // Randomized run against the model
    applyStimulus(1,0,0,0,0,1);
    checkOutput("rnd reset");
    for (int n = 0; n < 3000; n++) begin
      logic        r, b, d, h, y;
      logic [31:0] t;
      r = ($urandom_range(0,99) == 0);
      b = ($urandom_range(0,99) < 15);
      d = ($urandom_range(0,99) < 8);
      h = ($urandom_range(0,99) < 5);
      y = ($urandom_range(0,99) < 70);
      if ($urandom_range(0,3) == 0) t = $urandom;
      else t = 32'($urandom_range(0,511)) << 2;
      applyStimulus(r, b, d, t, h, y);
      checkOutput($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
